// File: rtl/seq_verificador_param.sv
// seq_verificador_param: memory-compare game core.
// The player repeats a stored sequence on the switches; each move is
// checked against an external combinational memory read port.
//
// Parameters:
//   DATA_W      width of chaves / memory data
//   ADDR_W      width of memory address and move counter
//   NUM_JOGADAS moves per round (1..2**ADDR_W)
//   TIMEOUT     cycles allowed per move while waiting (0 = no limit)
//
// Ports:
//   clock, reset   rising-edge clock, async active-high reset
//   iniciar        start / restart request (level)
//   chaves         player switches
//   mem_dado       memory data at mem_endereco (same cycle)
//   mem_endereco   current move index
//   pronto         round finished
//   acertou        finished with every move correct
//   errou          finished by wrong move or timeout
//   timeout        finished by timeout
//   db_igual       play register == mem_dado
//   db_estado      state code
//   db_contagem    move counter
module seq_verificador_param #(
    parameter int DATA_W      = 4,
    parameter int ADDR_W      = 4,
    parameter int NUM_JOGADAS = 16,
    parameter int TIMEOUT     = 3000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [DATA_W-1:0] chaves,
    input  logic [DATA_W-1:0] mem_dado,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic              pronto,
    output logic              acertou,
    output logic              errou,
    output logic              timeout,
    output logic              db_igual,
    output logic [3:0]        db_estado,
    output logic [ADDR_W-1:0] db_contagem
);

    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(NUM_JOGADAS - 1);
    localparam logic [TMO_W-1:0] TMO_LIM =
        TMO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit TMO_ON = (TIMEOUT > 0);

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARA    = 4'h1,
        ESPERA     = 4'h2,
        REGISTRA   = 4'h3,
        COMPARA    = 4'h4,
        PROXIMO    = 4'h5,
        FIM_ACERTO = 4'hA,
        FIM_TMO    = 4'hD,
        FIM_ERRO   = 4'hE
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] cont_q, cont_d;
    logic [DATA_W-1:0] jog_q, jog_d;
    logic [DATA_W-1:0] chaves_q;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              pronto_q, acertou_q, errou_q, timeout_q;
    logic              jogada;
    logic              igual;

    // A move is an all-zero to non-zero transition of the switches,
    // so holding keys down never counts twice.
    assign jogada = (|chaves) & ~(|chaves_q);
    assign igual  = (jog_q == mem_dado);

    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        jog_d    = jog_q;
        tmo_d    = tmo_q;
        case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARA;
            end
            PREPARA: begin
                estado_d = ESPERA;
            end
            ESPERA: begin
                tmo_d = tmo_q + 1'b1;
                // A move wins over a timeout landing on the same cycle.
                if (jogada) begin
                    estado_d = REGISTRA;
                end else if (TMO_ON && (tmo_q == TMO_LIM)) begin
                    estado_d = FIM_TMO;
                end
            end
            REGISTRA: begin
                jog_d    = chaves;
                estado_d = COMPARA;
            end
            COMPARA: begin
                if (!igual) begin
                    estado_d = FIM_ERRO;
                end else if (cont_q == ULTIMO) begin
                    estado_d = FIM_ACERTO;
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO: begin
                cont_d   = cont_q + 1'b1;
                tmo_d    = '0;
                estado_d = ESPERA;
            end
            FIM_ACERTO, FIM_ERRO, FIM_TMO: begin
                if (iniciar) estado_d = PREPARA;
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase
        // Clearing on entry makes the counter read 0 already in PREPARA.
        if (estado_d == PREPARA) begin
            cont_d = '0;
            jog_d  = '0;
            tmo_d  = '0;
        end
    end

    // Moore flags are registered from the next state so they are
    // valid on the first cycle spent in each final state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= INICIAL;
            cont_q    <= '0;
            jog_q     <= '0;
            chaves_q  <= '0;
            tmo_q     <= '0;
            pronto_q  <= 1'b0;
            acertou_q <= 1'b0;
            errou_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cont_q    <= cont_d;
            jog_q     <= jog_d;
            chaves_q  <= chaves;
            tmo_q     <= tmo_d;
            pronto_q  <= (estado_d == FIM_ACERTO) ||
                         (estado_d == FIM_ERRO) ||
                         (estado_d == FIM_TMO);
            acertou_q <= (estado_d == FIM_ACERTO);
            errou_q   <= (estado_d == FIM_ERRO) ||
                         (estado_d == FIM_TMO);
            timeout_q <= (estado_d == FIM_TMO);
        end
    end

    assign mem_endereco = cont_q;
    assign db_contagem  = cont_q;
    assign db_estado    = estado_q;
    assign db_igual     = igual;
    assign pronto       = pronto_q;
    assign acertou      = acertou_q;
    assign errou        = errou_q;
    assign timeout      = timeout_q;

endmodule
